// File: rtl/dh_t_matrix.sv
// Denavit-Hartenberg transform builder: top three rows of T from sin/cos/a/d, one shared multiplier.
// Define DH_T_MATRIX_SAT_EN to saturate products and negations; default build wraps.
module dh_t_matrix #(
  parameter int W         = 36,
  parameter int FRAC_BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [W-1:0]    sin_theta,
  input  logic [W-1:0]    cos_theta,
  input  logic [W-1:0]    sin_alpha,
  input  logic [W-1:0]    cos_alpha,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    d,
  output logic            busy,
  output logic            done,
  output logic [12*W-1:0] t_mat
);

  // state | meaning
  // IDLE  | waiting for en; operands latched on accept
  // MUL   | one shared product per cycle, steps 0..5
  // DONE  | t_mat complete, done pulse
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic signed [2*W-1:0] MAX_L = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] MIN_L = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]   MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]   MIN_W = {1'b1, {(W-1){1'b0}}};

  state_t state, state_nxt;
  logic [2:0] step;
  logic signed [W-1:0] s_t, c_t, s_a, c_a, a_r, d_r;
  logic signed [W-1:0] mul_x, mul_y;
  logic signed [2*W-1:0] prod, prod_sh;
  logic signed [W-1:0] red, res;
  logic [3:0] slot;
  logic neg;
  logic [W-1:0] ent [12];
  logic unused_hi;

  always_comb begin
    mul_x = s_t;
    mul_y = c_a;
    slot  = 4'd1;
    neg   = 1'b0;
    case (step)
      3'd0: begin mul_x = s_t; mul_y = c_a; slot = 4'd1; neg = 1'b1; end
      3'd1: begin mul_x = s_t; mul_y = s_a; slot = 4'd2; end
      3'd2: begin mul_x = a_r; mul_y = c_t; slot = 4'd3; end
      3'd3: begin mul_x = c_t; mul_y = c_a; slot = 4'd5; end
      3'd4: begin mul_x = c_t; mul_y = s_a; slot = 4'd6; neg = 1'b1; end
      3'd5: begin mul_x = a_r; mul_y = s_t; slot = 4'd7; end
      default: ;
    endcase
  end

  assign prod      = mul_x * mul_y;
  assign prod_sh   = prod >>> FRAC_BITS;
  assign unused_hi = ^prod_sh[2*W-1:W];

  always_comb begin
`ifdef DH_T_MATRIX_SAT_EN
    if (prod_sh > MAX_L)      red = MAX_W;
    else if (prod_sh < MIN_L) red = MIN_W;
    else                      red = prod_sh[W-1:0];
    if (!neg)                 res = red;
    else if (red == MIN_W)    res = MAX_W;
    else                      res = -red;
`else
    red = prod_sh[W-1:0];
    res = neg ? -red : red;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = MUL;
      MUL:     if (step == 3'd5) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      s_t   <= '0;
      c_t   <= '0;
      s_a   <= '0;
      c_a   <= '0;
      a_r   <= '0;
      d_r   <= '0;
      for (int k = 0; k < 12; k++) ent[k] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (en) begin
          s_t  <= sin_theta;
          c_t  <= cos_theta;
          s_a  <= sin_alpha;
          c_a  <= cos_alpha;
          a_r  <= a;
          d_r  <= d;
          step <= '0;
        end
        MUL: begin
          ent[slot] <= res;
          step      <= step + 3'd1;
          // Direct entries land on the edge into DONE so the matrix is whole while done is high.
          if (step == 3'd5) begin
            step   <= '0;
            ent[0]  <= c_t;
            ent[4]  <= s_t;
            ent[8]  <= '0;
            ent[9]  <= s_a;
            ent[10] <= c_a;
            ent[11] <= d_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == MUL);
  assign done = (state == DONE);

  for (genvar k = 0; k < 12; k++) begin : g_out
    assign t_mat[W*k +: W] = ent[k];
  end

endmodule

// File: tb/tb_dh_t_matrix.sv
// Self-checking bench for dh_t_matrix: directed plan vectors plus random jobs against a matrix model.
module tb_dh_t_matrix;
  localparam int W = 36;
  localparam int FRAC_BITS = 16;
  localparam logic signed [2*W-1:0] MAXP = 72'sd34359738367;
  localparam logic signed [2*W-1:0] MINP = -72'sd34359738368;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [W-1:0] sin_theta = '0, cos_theta = '0, sin_alpha = '0, cos_alpha = '0, a = '0, d = '0;
  logic busy, done;
  logic [12*W-1:0] t_mat;

  int n_chk = 0;
  int n_err = 0;

  dh_t_matrix #(.W(W), .FRAC_BITS(FRAC_BITS)) dut (
    .clk(clk), .rst(rst), .en(en),
    .sin_theta(sin_theta), .cos_theta(cos_theta),
    .sin_alpha(sin_alpha), .cos_alpha(cos_alpha),
    .a(a), .d(d), .busy(busy), .done(done), .t_mat(t_mat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] fx_mul(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
    logic signed [2*W-1:0] p;
    p = x * y;
    p = p >>> FRAC_BITS;
`ifdef DH_T_MATRIX_SAT_EN
    if (p > MAXP) p = MAXP;
    if (p < MINP) p = MINP;
`endif
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] fx_neg(input logic [W-1:0] x);
`ifdef DH_T_MATRIX_SAT_EN
    if (x == 36'h8_0000_0000) return 36'h7_FFFF_FFFF;
`endif
    return -x;
  endfunction

  function automatic logic [W-1:0] rnd(input bit full);
    logic [63:0] t;
    logic signed [W-1:0] r;
    int v;
    if (full) begin
      t = {$urandom(), $urandom()};
      return t[W-1:0];
    end
    v = int'($urandom_range(0, 131072)) - 65536;
    r = v;
    return r;
  endfunction

  function automatic logic [W-1:0] ent(input int k);
    return t_mat[W*k +: W];
  endfunction

  // Runs one job; optionally pokes en during MUL and DONE, scrambles inputs while busy.
  task automatic run_job(input logic [W-1:0] st, ct, sa, ca, aa, dd, input bit extra_en);
    logic [W-1:0] em [12];
    em[0]  = ct;                   em[1]  = fx_neg(fx_mul(st, ca));
    em[2]  = fx_mul(st, sa);       em[3]  = fx_mul(aa, ct);
    em[4]  = st;                   em[5]  = fx_mul(ct, ca);
    em[6]  = fx_neg(fx_mul(ct, sa)); em[7] = fx_mul(aa, st);
    em[8]  = '0;                   em[9]  = sa;
    em[10] = ca;                   em[11] = dd;
    @(negedge clk);
    sin_theta = st; cos_theta = ct; sin_alpha = sa; cos_alpha = ca; a = aa; d = dd;
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("busy_c%0d", k), {35'b0, busy}, {35'b0, (k <= 6)});
      chk($sformatf("done_c%0d", k), {35'b0, done}, {35'b0, (k == 7)});
      if (k >= 7)
        for (int e = 0; e < 12; e++) chk($sformatf("t_c%0d_e%0d", k, e), ent(e), em[e]);
      sin_theta = rnd(1); cos_theta = rnd(1); sin_alpha = rnd(1);
      cos_alpha = rnd(1); a = rnd(1); d = rnd(1);
      en = extra_en && (k == 3 || k == 7);
    end
    en = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_busy", {35'b0, busy}, '0);
    chk("rst_done", {35'b0, done}, '0);
    for (int e = 0; e < 12; e++) chk($sformatf("rst_t%0d", e), ent(e), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_job('0, 36'h1_0000, '0, 36'h1_0000, 36'h2_0000, 36'h3_0000, 1'b0);
    chk("p1_r0c3", ent(3), 36'h2_0000);
    chk("p1_r1c1", ent(5), 36'h1_0000);

    run_job(36'h1_0000, '0, 36'h1_0000, '0, 36'h2_0000, 36'h3_0000, 1'b0);
    chk("p2_r0c2", ent(2), 36'h1_0000);
    chk("p2_r0c1", ent(1), '0);
    chk("p2_r1c2", ent(6), '0);
    chk("p2_r1c3", ent(7), 36'h2_0000);

    run_job(36'hF_FFFF_8000, 36'h1_0000, '0, 36'h1_0000, 36'h1_0000, '0, 1'b0);
    chk("p3_r0c1", ent(1), 36'h0_0000_8000);
    chk("p3_r1c0", ent(4), 36'hF_FFFF_8000);
    chk("p3_r1c3", ent(7), 36'hF_FFFF_8000);

    run_job('0, 36'h2_0000, '0, '0, 36'h7_FFFF_FFFF, '0, 1'b0);
`ifdef DH_T_MATRIX_SAT_EN
    chk("p4_r0c3", ent(3), 36'h7_FFFF_FFFF);
`else
    chk("p4_r0c3", ent(3), 36'hF_FFFF_FFFE);
`endif

    run_job(36'h0_8000, 36'h0_C000, 36'hF_FFFF_4000, 36'h0_E000, 36'h5_0000, 36'h7_0000, 1'b1);

    // Reset in the middle of a job clears everything asynchronously.
    @(negedge clk);
    sin_theta = rnd(0); cos_theta = rnd(0); sin_alpha = rnd(0);
    cos_alpha = rnd(0); a = rnd(0); d = rnd(0);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", {35'b0, busy}, 36'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {35'b0, busy}, '0);
    chk("mid_rst_done", {35'b0, done}, '0);
    for (int e = 0; e < 12; e++) chk($sformatf("mid_rst_t%0d", e), ent(e), '0);
    @(negedge clk);
    rst = 1'b0;
    run_job(36'h0_B505, 36'h0_B505, 36'h1_0000, '0, 36'h1_8000, 36'hF_FFFF_0000, 1'b0);

    for (int j = 0; j < 30; j++) begin
      bit full;
      full = (j % 3 == 2);
      run_job(rnd(full), rnd(full), rnd(full), rnd(full), rnd(1), rnd(1), (j % 4 == 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
